// File: rtl/atomic_reader_pkg.sv
// Shared types and widths for the atomic counter read sequencer.
package atomic_reader_pkg;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_LO  = 3'd1,
    WAIT_LO = 3'd2,
    REQ_HI  = 3'd3,
    WAIT_HI = 3'd4,
    RESP    = 3'd5
  } state_e;

endpackage

// File: rtl/ack_timeout_timer.sv
// Per-access ack watchdog: cleared before each wait, counts wait cycles without ack.
module ack_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + TW'(1);

  // expired mirrors (cnt_q == LAST) so it is high during the final allowed wait cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else if (enable && !expired) begin
      cnt_q   <= cnt_inc;
      expired <= (cnt_inc == LAST);
    end
  end

endmodule

// File: rtl/atomic_count_reader.sv
// Turns one host read into an atomic low-word access plus a snapshot high-word access,
// returning a coherent 64-bit count (or a timeout error) on a valid/ready channel.
module atomic_count_reader
  import atomic_reader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_valid_i,
  output logic              rd_ready_o,
  output logic              req_o,
  output logic              atomic_o,
  input  logic              ack_i,
  input  logic [CNT_W-1:0]  count_i,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]  data_d;
  logic               err_d;
  logic               tmr_clear, tmr_enable, tmr_expired;

  ack_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  // Next-state and capture logic; ack outside the WAIT states is deliberately ignored
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    data_d     = data_o;
    err_d      = err_o;
    tmr_clear  = 1'b0;
    tmr_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_valid_i) state_d = REQ_LO;
      end
      REQ_LO: begin
        tmr_clear = 1'b1;
        state_d   = WAIT_LO;
      end
      WAIT_LO: begin
        tmr_enable = !ack_i;
        if (ack_i) begin
          lo_d    = count_i;
          state_d = REQ_HI;
        end else if (tmr_expired) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      REQ_HI: begin
        tmr_clear = 1'b1;
        state_d   = WAIT_HI;
      end
      WAIT_HI: begin
        tmr_enable = !ack_i;
        if (ack_i) begin
          data_d  = {count_i, lo_q};
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmr_expired) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (data_ready_i) begin
          data_d  = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      lo_q         <= '0;
      data_o       <= '0;
      err_o        <= 1'b0;
      rd_ready_o   <= 1'b1;
      req_o        <= 1'b0;
      atomic_o     <= 1'b0;
      data_valid_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      lo_q         <= lo_d;
      data_o       <= data_d;
      err_o        <= err_d;
      rd_ready_o   <= (state_d == IDLE);
      req_o        <= (state_d == REQ_LO) || (state_d == REQ_HI);
      atomic_o     <= (state_d == REQ_LO);
      data_valid_o <= (state_d == RESP);
    end
  end

endmodule

// File: tb/tb_atomic_count_reader.sv
// Bench for atomic_count_reader with a behavioural 64-bit counter model on the read port.
module tb_atomic_count_reader;
  import atomic_reader_pkg::*;

  localparam int unsigned TO = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              rd_valid_i;
  logic              rd_ready_o;
  logic              req_o;
  logic              atomic_o;
  logic              ack_i;
  logic [CNT_W-1:0]  count_i;
  logic              data_valid_o;
  logic              data_ready_i;
  logic [DATA_W-1:0] data_o;
  logic              err_o;

  atomic_count_reader #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rd_valid_i   (rd_valid_i),
    .rd_ready_o   (rd_ready_o),
    .req_o        (req_o),
    .atomic_o     (atomic_o),
    .ack_i        (ack_i),
    .count_i      (count_i),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .data_o       (data_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Counter model: value = base, optionally advancing by one per clock since base_cyc
  logic [63:0] base = 64'd0;
  int          base_cyc = 0;
  bit          inc = 1'b0;
  int          ack_delay = 1;
  bit          ack_en = 1'b1;
  bit          spur_on = 1'b0;
  int          n_req = 0;
  int          n_atomic = 0;
  logic [63:0] atomic_val = 64'd0;
  logic [31:0] snap = 32'd0;

  int n_pass = 0;
  int n_total = 0;

  function automatic logic [63:0] cur_ctr();
    return inc ? base + 64'(cyc - base_cyc) : base;
  endfunction

  // Counter block: atomic access returns low word and snapshots high; plain returns snapshot
  initial begin : counter_model
    bit          pend;
    bit          pend_atomic;
    int          left;
    logic [63:0] v;
    pend = 1'b0; pend_atomic = 1'b0; left = 0;
    ack_i = 1'b0; count_i = '0;
    forever begin
      @(negedge clk); #1;
      ack_i   = spur_on;
      count_i = spur_on ? 32'hDEAD_BEEF : $urandom;
      if (!reset_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          left--;
          if (left <= 0) begin
            pend = 1'b0;
            if (ack_en) begin
              ack_i = 1'b1;
              if (pend_atomic) begin
                v          = cur_ctr();
                snap       = v[63:32];
                count_i    = v[31:0];
                atomic_val = v;
              end else begin
                count_i = snap;
              end
            end
          end
        end
        if (req_o) begin
          pend        = 1'b1;
          left        = ack_delay;
          pend_atomic = atomic_o;
          n_req++;
          if (atomic_o) n_atomic++;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rd_ready"}, 64'(rd_ready_o), 64'd1);
    chk({tag, "_req"}, 64'(req_o), 64'd0);
    chk({tag, "_atomic"}, 64'(atomic_o), 64'd0);
    chk({tag, "_valid"}, 64'(data_valid_o), 64'd0);
    chk({tag, "_data"}, data_o, 64'd0);
    chk({tag, "_err"}, 64'(err_o), 64'd0);
  endtask

  task automatic wait_valid(input string tag);
    int b;
    b = 0;
    while (!data_valid_o && b < 100) begin step(); b++; end
    chk(tag, 64'(data_valid_o), 64'd1);
  endtask

  task automatic do_read(input int ready_delay, output logic [63:0] got, output logic got_err);
    int b;
    rd_valid_i = 1'b1;
    b = 0;
    while (!rd_ready_o && b < 50) begin step(); b++; end
    step();
    rd_valid_i = 1'b0;
    wait_valid("resp_arrives");
    repeat (ready_delay) step();
    got     = data_o;
    got_err = err_o;
    data_ready_i = 1'b1;
    step();
    data_ready_i = 1'b0;
  endtask

  initial begin : stimulus
    logic [63:0] got;
    logic        gerr;
    logic [63:0] d0;
    logic [63:0] exp;
    int          q_req;
    int          q_atm;
    int          b;
    bit          early;
    bit          unstable;

    reset_n = 1'b0; rd_valid_i = 1'b0; data_ready_i = 1'b0;
    repeat (2) step();
    chk_reset_outs("reset");
    reset_n = 1'b1;
    step();

    // Exact cycle timing of one read with a one-cycle-ack counter
    base = 64'h0000_0001_FFFF_FFFE; inc = 1'b0; ack_delay = 1;
    q_req = n_req;
    rd_valid_i = 1'b1;
    step();
    rd_valid_i = 1'b0;
    chk("t1_req_lo", {62'd0, req_o, atomic_o}, 64'd3);
    step();
    chk("t2_req_off", 64'(req_o), 64'd0);
    step();
    chk("t3_req_hi", {62'd0, req_o, atomic_o}, 64'd2);
    step();
    chk("t4_no_valid", {62'd0, req_o, data_valid_o}, 64'd0);
    step();
    chk("t5_valid", 64'(data_valid_o), 64'd1);
    chk("t5_data", data_o, 64'h0000_0001_FFFF_FFFE);
    chk("t5_err", 64'(err_o), 64'd0);
    data_ready_i = 1'b1;
    step();
    data_ready_i = 1'b0;
    chk("t1_req_count", 64'(n_req - q_req), 64'd2);

    // Low-word wrap between the two accesses must not tear
    base = 64'h0000_0002_FFFF_FFFD; inc = 1'b1; base_cyc = cyc;
    do_read(0, got, gerr);
    chk("wrap_data", got, 64'h0000_0002_FFFF_FFFF);
    chk("wrap_err", 64'(gerr), 64'd0);
    inc = 1'b0;

    // Back-pressure with a second command held pending
    base = {$urandom, $urandom};
    rd_valid_i = 1'b1;
    step();
    wait_valid("bp_resp");
    d0 = data_o;
    chk("bp_data", d0, base);
    q_req = n_req;
    unstable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!data_valid_o || data_o !== d0 || rd_ready_o) unstable = 1'b1;
    end
    chk("bp_stable", 64'(unstable), 64'd0);
    chk("bp_no_new_req", 64'(n_req - q_req), 64'd0);
    data_ready_i = 1'b1;
    step();
    data_ready_i = 1'b0;
    chk("bp_idle_after", 64'(rd_ready_o), 64'd1);
    step();
    rd_valid_i = 1'b0;
    chk("bp_second_accept", {62'd0, req_o, atomic_o}, 64'd3);
    wait_valid("bp_second_resp");
    chk("bp_second_data", data_o, base);
    data_ready_i = 1'b1;
    step();
    data_ready_i = 1'b0;

    // Dead counter: error response TO+1 cycles after the pulse, no second request
    ack_en = 1'b0;
    q_req = n_req;
    rd_valid_i = 1'b1;
    step();
    rd_valid_i = 1'b0;
    chk("to_pulse", {62'd0, req_o, atomic_o}, 64'd3);
    early = 1'b0;
    for (int k = 1; k <= int'(TO); k++) begin
      step();
      if (data_valid_o) early = 1'b1;
    end
    chk("to_not_early", 64'(early), 64'd0);
    step();
    chk("to_valid", 64'(data_valid_o), 64'd1);
    chk("to_err", 64'(err_o), 64'd1);
    chk("to_data", data_o, 64'd0);
    chk("to_single_req", 64'(n_req - q_req), 64'd1);
    data_ready_i = 1'b1;
    step();
    data_ready_i = 1'b0;
    ack_en = 1'b1;

    // Ack in the final allowed cycle wins; one cycle later times out
    base = {$urandom, $urandom}; ack_delay = int'(TO);
    do_read(1, got, gerr);
    chk("edge_ack_data", got, base);
    chk("edge_ack_err", 64'(gerr), 64'd0);
    ack_delay = int'(TO) + 1;
    q_req = n_req;
    do_read(0, got, gerr);
    chk("edge_to_err", 64'(gerr), 64'd1);
    chk("edge_to_data", got, 64'd0);
    chk("edge_to_reqs", 64'(n_req - q_req), 64'd1);
    ack_delay = 1;
    repeat (3) step();

    // Spurious acks (and a stray ready) in IDLE and RESP
    spur_on = 1'b1; data_ready_i = 1'b1;
    step();
    spur_on = 1'b0; data_ready_i = 1'b0;
    step();
    chk("spur_idle_ready", 64'(rd_ready_o), 64'd1);
    chk("spur_idle_quiet", {62'd0, req_o, data_valid_o}, 64'd0);
    base = {$urandom, $urandom};
    rd_valid_i = 1'b1;
    step();
    rd_valid_i = 1'b0;
    wait_valid("spur_resp");
    d0 = data_o;
    spur_on = 1'b1;
    step();
    spur_on = 1'b0;
    step();
    chk("spur_resp_valid", 64'(data_valid_o), 64'd1);
    chk("spur_resp_data", data_o, base);
    data_ready_i = 1'b1;
    step();
    data_ready_i = 1'b0;
    base = {$urandom, $urandom};
    do_read(0, got, gerr);
    chk("spur_next_data", got, base);

    // Reset while waiting for the high-word ack
    ack_delay = 3;
    rd_valid_i = 1'b1;
    step();
    rd_valid_i = 1'b0;
    b = 0;
    while (!(req_o && !atomic_o) && b < 20) begin step(); b++; end
    chk("rst_reached_req_hi", {62'd0, req_o, atomic_o}, 64'd2);
    step();
    reset_n = 1'b0;
    #1;
    chk_reset_outs("rst_mid");
    step();
    reset_n = 1'b1;
    step();
    base = {$urandom, $urandom}; ack_delay = 1;
    do_read(0, got, gerr);
    chk("rst_after_data", got, base);
    chk("rst_after_err", 64'(gerr), 64'd0);

    // Randomised reads: coherent snapshot regardless of ack latency or counter motion
    for (int n = 0; n < 20; n++) begin
      base      = {$urandom, $urandom};
      inc       = 1'($urandom_range(0, 1));
      ack_delay = int'($urandom_range(1, 4));
      base_cyc  = cyc;
      q_req     = n_req;
      q_atm     = n_atomic;
      do_read(int'($urandom_range(0, 3)), got, gerr);
      exp = inc ? atomic_val : base;
      chk("rnd_data", got, exp);
      chk("rnd_err", 64'(gerr), 64'd0);
      chk("rnd_reqs", {32'(n_req - q_req), 32'(n_atomic - q_atm)}, {32'd2, 32'd1});
      if (inc) chk("rnd_window", 64'((got - base) < 64'd16), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
